// File: rtl/card_deal_arbiter.sv
// Round-robin player/dealer arbiter in front of a shared random-card generator.
// Optional macro DECK_TRACK_EN adds a dealt-card mask, duplicate rejection and a deck-empty error.
module card_deal_arbiter #(
    parameter int GEN_TIMEOUT = 15,
    parameter int MAX_RETRIES = 63
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       shuffle_i,
    input  logic [1:0] req_i,
    output logic [1:0] ack_o,
    output logic [5:0] card_o,
    output logic [3:0] rank_o,
    output logic       gen_req_o,
    input  logic       gen_valid_i,
    input  logic [5:0] gen_data_i,
    output logic       busy_o,
    output logic       err_o,
    output logic [5:0] cards_left_o
);
    localparam int TW = $clog2(GEN_TIMEOUT + 1);
    localparam int RW = $clog2(MAX_RETRIES + 1);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, CHECK, GRANT, DONE} state_e;

    state_e        state_q, state_d;
    logic          grantee_q, grantee_d;   // 0 = player, 1 = dealer
    logic          ptr_q, ptr_d;
    logic          err_q, err_d;
    logic [TW-1:0] to_q, to_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [5:0]    data_q, data_d;
    logic [5:0]    card_q, card_d;
    logic [3:0]    rank_q, rank_d;
    logic          reject;

`ifdef DECK_TRACK_EN
    logic [51:0] dealt_q, dealt_d;
    logic [5:0]  left_q, left_d;
    logic [63:0] dealt_ext;
    // widened so an out-of-range draw indexes a zero bit instead of past the mask
    assign dealt_ext = {12'd0, dealt_q};
    assign reject    = (data_q >= 6'd52) || dealt_ext[data_q];
`else
    assign reject    = (data_q >= 6'd52);
`endif

    function automatic logic [3:0] rank_of(input logic [5:0] v);
        logic [3:0] r;
        if (v >= 6'd39)      r = 4'(v - 6'd39);
        else if (v >= 6'd26) r = 4'(v - 6'd26);
        else if (v >= 6'd13) r = 4'(v - 6'd13);
        else                 r = v[3:0];
        return r + 4'd1;
    endfunction

    always_comb begin
        state_d   = state_q;
        grantee_d = grantee_q;
        ptr_d     = ptr_q;
        err_d     = err_q;
        to_d      = to_q;
        retry_d   = retry_q;
        data_d    = data_q;
        card_d    = card_q;
        rank_d    = rank_q;
`ifdef DECK_TRACK_EN
        dealt_d   = dealt_q;
        left_d    = left_q;
`endif
        case (state_q)
            IDLE: begin
                if (shuffle_i) begin
`ifdef DECK_TRACK_EN
                    dealt_d = '0;
                    left_d  = 6'd52;
`endif
                    err_d   = 1'b0;
                end else if (!err_q && req_i != 2'b00) begin
`ifdef DECK_TRACK_EN
                    if (left_q == 6'd0) err_d = 1'b1;
                    else begin
`else
                    begin
`endif
                        grantee_d = (req_i == 2'b11) ? ptr_q : req_i[1];
                        retry_d   = '0;
                        state_d   = REQ;
                    end
                end
            end
            REQ: begin
                to_d    = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (gen_valid_i) begin
                    data_d  = gen_data_i;
                    state_d = CHECK;
                end else if (to_q + TW'(1) == TW'(GEN_TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    to_d = to_q + TW'(1);
                end
            end
            CHECK: begin
                if (reject) begin
                    if (retry_q + RW'(1) == RW'(MAX_RETRIES)) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        retry_d = retry_q + RW'(1);
                        state_d = REQ;
                    end
                end else begin
                    // card/rank registers load here so they are valid during the GRANT pulse
                    card_d  = data_q;
                    rank_d  = rank_of(data_q);
                    state_d = GRANT;
                end
            end
            GRANT: begin
                ptr_d   = ~grantee_q;
`ifdef DECK_TRACK_EN
                dealt_d = dealt_q | (52'd1 << data_q);
                left_d  = (left_q == 6'd0) ? 6'd0 : left_q - 6'd1;
`endif
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            grantee_q <= 1'b0;
            ptr_q     <= 1'b0;
            err_q     <= 1'b0;
            to_q      <= '0;
            retry_q   <= '0;
            data_q    <= '0;
            card_q    <= '0;
            rank_q    <= '0;
`ifdef DECK_TRACK_EN
            dealt_q   <= '0;
            left_q    <= 6'd52;
`endif
        end else begin
            state_q   <= state_d;
            grantee_q <= grantee_d;
            ptr_q     <= ptr_d;
            err_q     <= err_d;
            to_q      <= to_d;
            retry_q   <= retry_d;
            data_q    <= data_d;
            card_q    <= card_d;
            rank_q    <= rank_d;
`ifdef DECK_TRACK_EN
            dealt_q   <= dealt_d;
            left_q    <= left_d;
`endif
        end
    end

    assign ack_o     = (state_q == GRANT) ? (grantee_q ? 2'b10 : 2'b01) : 2'b00;
    assign gen_req_o = (state_q == REQ);
    assign busy_o    = (state_q != IDLE);
    assign err_o     = err_q;
    assign card_o    = card_q;
    assign rank_o    = rank_q;
`ifdef DECK_TRACK_EN
    assign cards_left_o = left_q;
`else
    assign cards_left_o = 6'd52;
`endif

endmodule

// File: tb/tb_card_deal_arbiter.sv
// Self-checking bench for card_deal_arbiter: directed vector table, hand sequences, and
// randomized traffic checked against a transaction-level model.
module tb_card_deal_arbiter;
    logic       clk_i = 1'b0, rst_i = 1'b0, shuffle_i = 1'b0, gen_valid_i = 1'b0;
    logic [1:0] req_i = 2'b00;
    logic [5:0] gen_data_i = 6'd0;
    logic [1:0] ack_o;
    logic [5:0] card_o, cards_left_o;
    logic [3:0] rank_o;
    logic       gen_req_o, busy_o, err_o;

    card_deal_arbiter dut (
        .clk_i(clk_i), .rst_i(rst_i), .shuffle_i(shuffle_i), .req_i(req_i), .ack_o(ack_o),
        .card_o(card_o), .rank_o(rank_o), .gen_req_o(gen_req_o), .gen_valid_i(gen_valid_i),
        .gen_data_i(gen_data_i), .busy_o(busy_o), .err_o(err_o), .cards_left_o(cards_left_o)
    );

    always #5 clk_i = ~clk_i;

`ifdef DECK_TRACK_EN
    localparam bit TRK = 1'b1;
`else
    localparam bit TRK = 1'b0;
`endif

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // generator responder and requester bookkeeping
    int          cd = 0, greq_cnt = 0, cyc_no = 0, cur_lat = 1;
    bit          gen_en = 1'b1, rand_lat = 1'b0, autodrop = 1'b1;
    int unsigned gq[$];
    logic [1:0]  acks[$];
    int          cards[$];

    // transaction-level reference model
    bit          mdl_on = 1'b0, in_txn = 1'b0, exp_valid = 1'b0, ptr_m = 1'b0;
    int          s_cyc, lat_sum, exp_ack_cyc, avail, exp_g, exp_card, left_m, n_rg;
    bit [63:0]   dealt_m;

    task automatic mdl_pre();
        if (!in_txn && cyc_no >= avail && req_i != 2'b00) begin
            s_cyc     = cyc_no;
            exp_g     = (req_i == 2'b01) ? 0 : (req_i == 2'b10) ? 1 : int'(ptr_m);
            lat_sum   = 0;
            exp_valid = 1'b0;
            in_txn    = 1'b1;
        end
    endtask

    task automatic mdl_draw(input int v);
        if (!exp_valid) begin
            lat_sum += 2 + cur_lat;
            if (v < 52 && !(TRK && dealt_m[v])) begin
                exp_valid   = 1'b1;
                exp_card    = v;
                exp_ack_cyc = s_cyc + lat_sum + 1;
            end
        end
    endtask

    task automatic mdl_ack();
        if (!in_txn || !exp_valid) chk("rand spurious ack", int'(ack_o), 0);
        else begin
            chk("rand grantee", int'(ack_o), exp_g ? 2 : 1);
            chk("rand ack cycle", cyc_no, exp_ack_cyc);
            chk("rand card", int'(card_o), exp_card);
            chk("rand rank", int'(rank_o), exp_card % 13 + 1);
            chk("rand err", int'(err_o), 0);
            ptr_m             = (exp_g == 0);
            dealt_m[exp_card] = 1'b1;
            left_m--;
            avail  = cyc_no + 2;
            in_txn = 1'b0;
            n_rg++;
        end
    endtask

    task automatic cyc();
        logic [1:0] acked;
        if (mdl_on) mdl_pre();
        @(posedge clk_i); #1;
        cyc_no++;
        gen_valid_i = 1'b0;
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                gen_valid_i = 1'b1;
                if (gq.size() != 0) gen_data_i = 6'(gq.pop_front());
                else gen_data_i = 6'(($urandom_range(0, 3) == 0) ? $urandom_range(52, 63)
                                                                 : $urandom_range(0, 51));
                if (mdl_on) mdl_draw(int'(gen_data_i));
            end
        end
        if (gen_req_o) begin
            greq_cnt++;
            cur_lat = rand_lat ? int'($urandom_range(1, 3)) : 1;
            if (gen_en) cd = cur_lat;
        end
        acked = ack_o;
        if (acked != 2'b00) begin
            acks.push_back(acked);
            cards.push_back(int'(card_o));
            if (mdl_on) mdl_ack();
            if (autodrop) req_i = req_i & ~acked;
        end
        if (mdl_on)
            for (int b = 0; b < 2; b++)
                if (!req_i[b] && !acked[b] && $urandom_range(0, 3) == 0) req_i[b] = 1'b1;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy_o && k < 200) begin cyc(); k++; end
        chk("idle reached", int'(busy_o), 0);
    endtask

    task automatic deal1(input logic [1:0] r);
        int a0 = acks.size();
        int k  = 0;
        req_i = r;
        while (acks.size() == a0 && k < 600) begin cyc(); k++; end
        chk("deal acked", acks.size(), a0 + 1);
        req_i = 2'b00;
        wait_idle();
    endtask

    task automatic do_shuffle();
        shuffle_i = 1'b1;
        cyc();
        shuffle_i = 1'b0;
    endtask

    typedef struct {
        logic [1:0] req; logic gv; logic [5:0] gd;
        logic [1:0] ack; logic greq; logic busy; logic [5:0] card; logic [3:0] rank; int left;
    } vec_t;

    function automatic vec_t mk(logic [1:0] r, logic gv, logic [5:0] gd, logic [1:0] a,
                                logic g, logic b, logic [5:0] c, logic [3:0] rk, int l);
        vec_t v;
        v.req = r; v.gv = gv; v.gd = gd; v.ack = a; v.greq = g; v.busy = b;
        v.card = c; v.rank = rk; v.left = l;
        return v;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tv[19];
        int   l1, l2, g0, a0, k;
        l1 = TRK ? 51 : 52;
        l2 = TRK ? 50 : 52;
        // player draws 5 (min latency), then dealer draws 60, 63, 20
        tv[0]  = mk(2'd1, 0, 0,  2'd0, 0, 0, 0,  0, 52);
        tv[1]  = mk(2'd1, 0, 0,  2'd0, 1, 1, 0,  0, 52);
        tv[2]  = mk(2'd1, 1, 5,  2'd0, 0, 1, 0,  0, 52);
        tv[3]  = mk(2'd1, 0, 0,  2'd0, 0, 1, 0,  0, 52);
        tv[4]  = mk(2'd0, 0, 0,  2'd1, 0, 1, 5,  6, 52);
        tv[5]  = mk(2'd0, 0, 0,  2'd0, 0, 1, 5,  6, l1);
        tv[6]  = mk(2'd2, 0, 0,  2'd0, 0, 0, 5,  6, l1);
        tv[7]  = mk(2'd2, 0, 0,  2'd0, 1, 1, 5,  6, l1);
        tv[8]  = mk(2'd2, 1, 60, 2'd0, 0, 1, 5,  6, l1);
        tv[9]  = mk(2'd2, 0, 0,  2'd0, 0, 1, 5,  6, l1);
        tv[10] = mk(2'd2, 0, 0,  2'd0, 1, 1, 5,  6, l1);
        tv[11] = mk(2'd2, 1, 63, 2'd0, 0, 1, 5,  6, l1);
        tv[12] = mk(2'd2, 0, 0,  2'd0, 0, 1, 5,  6, l1);
        tv[13] = mk(2'd2, 0, 0,  2'd0, 1, 1, 5,  6, l1);
        tv[14] = mk(2'd2, 1, 20, 2'd0, 0, 1, 5,  6, l1);
        tv[15] = mk(2'd2, 0, 0,  2'd0, 0, 1, 5,  6, l1);
        tv[16] = mk(2'd0, 0, 0,  2'd2, 0, 1, 20, 8, l1);
        tv[17] = mk(2'd0, 0, 0,  2'd0, 0, 1, 20, 8, l2);
        tv[18] = mk(2'd0, 0, 0,  2'd0, 0, 0, 20, 8, l2);

        repeat (2) @(posedge clk_i);
        #1;
        chk("reset ack", int'(ack_o), 0);
        chk("reset gen_req", int'(gen_req_o), 0);
        chk("reset busy", int'(busy_o), 0);
        chk("reset err", int'(err_o), 0);
        chk("reset card", int'(card_o), 0);
        chk("reset rank", int'(rank_o), 0);
        chk("reset cards_left", int'(cards_left_o), 52);
        rst_i = 1'b1;

        for (int i = 0; i < 19; i++) begin
            req_i = tv[i].req; gen_valid_i = tv[i].gv; gen_data_i = tv[i].gd;
            #1;
            chk($sformatf("row%0d ack", i), int'(ack_o), int'(tv[i].ack));
            chk($sformatf("row%0d gen_req", i), int'(gen_req_o), int'(tv[i].greq));
            chk($sformatf("row%0d busy", i), int'(busy_o), int'(tv[i].busy));
            chk($sformatf("row%0d card", i), int'(card_o), int'(tv[i].card));
            chk($sformatf("row%0d rank", i), int'(rank_o), int'(tv[i].rank));
            chk($sformatf("row%0d err", i), int'(err_o), 0);
            chk($sformatf("row%0d cards_left", i), int'(cards_left_o), tv[i].left);
            @(posedge clk_i); #1;
        end
        gen_valid_i = 1'b0;
        req_i = 2'b00;

        // both requesters held: grants alternate starting at player
        autodrop = 1'b0;
        acks.delete(); cards.delete();
        gq = {1, 2, 3, 4};
        req_i = 2'b11;
        k = 0;
        while (acks.size() < 4 && k < 100) begin cyc(); k++; end
        req_i = 2'b00;
        autodrop = 1'b1;
        chk("rr ack count", acks.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr ack%0d", i), (i < acks.size()) ? int'(acks[i]) : 0, (i % 2) ? 2 : 1);
            chk($sformatf("rr card%0d", i), (i < cards.size()) ? cards[i] : -1, i + 1);
        end
        wait_idle();

`ifdef DECK_TRACK_EN
        do_shuffle();
        chk("trk shuffle left", int'(cards_left_o), 52);
        gq = {7};
        deal1(2'b01);
        chk("trk first card", cards[$], 7);
        g0 = greq_cnt;
        gq = {7, 8};
        deal1(2'b01);
        chk("trk dup rejected card", cards[$], 8);
        chk("trk dup gen_req count", greq_cnt - g0, 2);
        for (int v = 0; v < 52; v++)
            if (v != 7 && v != 8) begin
                gq.push_back(v);
                deal1(2'b01);
            end
        chk("trk deck empty left", int'(cards_left_o), 0);
        g0 = greq_cnt; a0 = acks.size();
        req_i = 2'b01;
        repeat (4) cyc();
        req_i = 2'b00;
        chk("trk empty err", int'(err_o), 1);
        chk("trk empty no gen_req", greq_cnt - g0, 0);
        chk("trk empty no ack", acks.size(), a0);
        do_shuffle();
        chk("trk reshuffle err", int'(err_o), 0);
        chk("trk reshuffle left", int'(cards_left_o), 52);
`else
        gq = {7};
        deal1(2'b01);
        g0 = greq_cnt;
        gq = {7};
        deal1(2'b01);
        chk("dup allowed card", cards[$], 7);
        chk("dup allowed gen_req count", greq_cnt - g0, 1);
        chk("no-track cards_left", int'(cards_left_o), 52);
`endif

        // generator silent: timeout error 17 cycles after the IDLE sample
        gen_en = 1'b0;
        g0 = greq_cnt; a0 = acks.size();
        req_i = 2'b01;
        k = 0;
        while (!err_o && k < 40) begin cyc(); k++; end
        chk("timeout err cycle", k, 17);
        chk("timeout err", int'(err_o), 1);
        chk("timeout no ack", acks.size(), a0);
        chk("timeout gen_req count", greq_cnt - g0, 1);
        req_i = 2'b10;
        repeat (8) cyc();
        chk("err blocks gen_req", greq_cnt - g0, 1);
        chk("err blocks busy", int'(busy_o), 0);
        chk("err sticky", int'(err_o), 1);
        req_i = 2'b00;
        do_shuffle();
        chk("shuffle clears err", int'(err_o), 0);
        gen_en = 1'b1;

        // reset asserted while waiting on the generator
        gen_en = 1'b0;
        req_i = 2'b01;
        cyc(); cyc();
        chk("pre-reset busy in WAIT", int'(busy_o), 1);
        #2 rst_i = 1'b0;
        #1;
        chk("midrst ack", int'(ack_o), 0);
        chk("midrst gen_req", int'(gen_req_o), 0);
        chk("midrst busy", int'(busy_o), 0);
        chk("midrst err", int'(err_o), 0);
        chk("midrst card", int'(card_o), 0);
        chk("midrst rank", int'(rank_o), 0);
        chk("midrst cards_left", int'(cards_left_o), 52);
        req_i = 2'b00; cd = 0; gen_en = 1'b1;
        @(negedge clk_i) rst_i = 1'b1;
        @(posedge clk_i); #1;
        gen_valid_i = 1'b1; gen_data_i = 6'd9;
        @(posedge clk_i); #1;
        gen_valid_i = 1'b0;
        a0 = acks.size();
        repeat (3) cyc();
        chk("post-reset valid ignored busy", int'(busy_o), 0);
        chk("post-reset valid ignored card", int'(card_o), 0);
        chk("post-reset no ack", acks.size(), a0);

        // randomized traffic from reset state
        in_txn = 1'b0; avail = cyc_no; ptr_m = 1'b0; dealt_m = '0; left_m = 52; n_rg = 0;
        rand_lat = 1'b1; gq.delete();
        mdl_on = 1'b1;
        k = 0;
        while (n_rg < 30 && k < 5000) begin cyc(); k++; end
        mdl_on = 1'b0;
        req_i = 2'b00;
        chk("rand grant count", n_rg, 30);
        wait_idle();
        chk("rand cards_left", int'(cards_left_o), TRK ? left_m : 52);
        chk("rand no err", int'(err_o), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
